id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/dlx_pkg.sv | 66 ++++++
 rtl/dlx_decoder.sv | 112 +++++++++++
 rtl/id_stage.sv | 97 +++++++++
 tb/tb_id_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX decode definitions: opcode/func encodings, instruction field
// positions, and the enums and decoded bundle passed from ID to EX.
package dlx_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS1_HI = 25;
    localparam int RS1_LO = 21;
    localparam int RS2_HI = 20;
    localparam int RS2_LO = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 15;
    localparam int OFS_HI = 25;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LHI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLL = 6'h04;
    localparam logic [5:0] FN_SRL = 6'h06;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SLT, ALU_PASSB
    } alu_op_t;

    typedef enum logic [2:0] {
        BR_NONE, BR_BEQZ, BR_BNEZ, BR_J, BR_JAL
    } branch_t;

    typedef struct packed {
        alu_op_t     alu_op;
        logic [31:0] imm;
        logic        use_imm;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
        branch_t     branch;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_rs1;
        logic        use_rs2;
    } decoded_t;

endpackage

// File: rtl/dlx_decoder.sv
// Purely combinational DLX instruction decoder: one instruction word in,
// one decoded control/immediate bundle out.
module dlx_decoder
    import dlx_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    dec
);

    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  fa;
    logic [4:0]  fb;
    logic [4:0]  fc;
    logic [31:0] imm_s;
    logic [31:0] imm_z;
    logic [31:0] imm_h;
    logic [31:0] imm_j;

    assign opcode = instr[OPC_HI:OPC_LO];
    assign func   = instr[FN_HI:FN_LO];
    assign fa     = instr[RS1_HI:RS1_LO];
    assign fb     = instr[RS2_HI:RS2_LO];
    assign fc     = instr[RD_HI:RD_LO];
    assign imm_s  = {{16{instr[IMM_HI]}}, instr[IMM_HI:0]};
    assign imm_z  = {16'h0000, instr[IMM_HI:0]};
    assign imm_h  = {instr[IMM_HI:0], 16'h0000};
    assign imm_j  = {{6{instr[OFS_HI]}}, instr[OFS_HI:0]};

    always_comb begin
        dec = '0;
        case (opcode)
            OP_RTYPE: begin
                dec.rs1     = fa;
                dec.rs2     = fb;
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.rd      = fc;
                case (func)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_XOR:  dec.alu_op = ALU_XOR;
                    FN_SLL:  dec.alu_op = ALU_SLL;
                    FN_SRL:  dec.alu_op = ALU_SRL;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
                dec.rs1     = fa;
                dec.use_rs1 = 1'b1;
                dec.rd      = fb;
                dec.use_imm = 1'b1;
                dec.imm     = (opcode == OP_ADDI) ? imm_s : imm_z;
                case (opcode)
                    OP_ANDI: dec.alu_op = ALU_AND;
                    OP_ORI:  dec.alu_op = ALU_OR;
                    OP_XORI: dec.alu_op = ALU_XOR;
                    default: dec.alu_op = ALU_ADD;
                endcase
            end
            OP_LHI: begin
                dec.rd      = fb;
                dec.use_imm = 1'b1;
                dec.imm     = imm_h;
                dec.alu_op  = ALU_PASSB;
            end
            OP_LW: begin
                dec.rs1      = fa;
                dec.use_rs1  = 1'b1;
                dec.rd       = fb;
                dec.use_imm  = 1'b1;
                dec.imm      = imm_s;
                dec.mem_read = 1'b1;
            end
            // Store data comes from the [20:16] field, so it is a second source.
            OP_SW: begin
                dec.rs1       = fa;
                dec.rs2       = fb;
                dec.use_rs1   = 1'b1;
                dec.use_rs2   = 1'b1;
                dec.use_imm   = 1'b1;
                dec.imm       = imm_s;
                dec.mem_write = 1'b1;
            end
            OP_BEQZ, OP_BNEZ: begin
                dec.rs1     = fa;
                dec.use_rs1 = 1'b1;
                dec.imm     = imm_s;
                dec.branch  = (opcode == OP_BEQZ) ? BR_BEQZ : BR_BNEZ;
            end
            OP_J: begin
                dec.imm    = imm_j;
                dec.branch = BR_J;
            end
            OP_JAL: begin
                dec.imm    = imm_j;
                dec.branch = BR_JAL;
                dec.rd     = LINK_REG;
            end
            default: dec.illegal = 1'b1;
        endcase

        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/id_stage.sv
// DLX instruction-decode stage: decoder, load-use/hold/flush hazard control,
// register-file read address muxing and the ID/EX pipeline register.
module id_stage
    import dlx_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_ready,
    input  logic            flush,
    input  logic            ex_hold,
    output logic [4:0]      Rs1,
    output logic [4:0]      Rs2,
    output logic            ex_valid,
    output alu_op_t         ex_alu_op,
    output logic [XLEN-1:0] ex_imm,
    output logic            ex_use_imm,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_illegal,
    output branch_t         ex_branch,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_pc
);

    decoded_t   dec;
    logic       load_use;
    logic       load_bubble;
    logic [4:0] held_rs1;
    logic [4:0] held_rs2;

    dlx_decoder u_decoder (
        .instr (if_instr),
        .dec   (dec)
    );

    always_comb begin
        load_use = if_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                   ((dec.use_rs1 && (dec.rs1 == ex_rd)) ||
                    (dec.use_rs2 && (dec.rs2 == ex_rd)));

        load_bubble = reset || flush || (!ex_hold && (load_use || !if_valid));

        if (reset)
            if_ready = 1'b0;
        else if (flush)
            if_ready = 1'b1;
        else if (ex_hold || load_use)
            if_ready = 1'b0;
        else
            if_ready = 1'b1;

        // While EX is frozen the register file must keep returning the held op's operands.
        if (!reset && !flush && ex_hold) begin
            Rs1 = held_rs1;
            Rs2 = held_rs2;
        end else begin
            Rs1 = dec.rs1;
            Rs2 = dec.rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (load_bubble) begin
            ex_valid     <= 1'b0;
            ex_alu_op    <= ALU_ADD;
            ex_imm       <= '0;
            ex_use_imm   <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_illegal   <= 1'b0;
            ex_branch    <= BR_NONE;
            ex_rd        <= 5'd0;
            ex_pc        <= '0;
            held_rs1     <= 5'd0;
            held_rs2     <= 5'd0;
        end else if (!ex_hold) begin
            ex_valid     <= 1'b1;
            ex_alu_op    <= dec.alu_op;
            ex_imm       <= dec.imm;
            ex_use_imm   <= dec.use_imm;
            ex_mem_read  <= dec.mem_read;
            ex_mem_write <= dec.mem_write;
            ex_illegal   <= dec.illegal;
            ex_branch    <= dec.branch;
            ex_rd        <= dec.rd;
            ex_pc        <= if_pc;
            held_rs1     <= dec.rs1;
            held_rs2     <= dec.rs2;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: decode, load-use stall,
// hold, flush, illegal ops and reset behaviour.
module tb_id_stage;
    import dlx_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = 32'h0;
    logic [31:0] if_pc = 32'h0;
    logic        if_ready;
    logic        flush = 1'b0;
    logic        ex_hold = 1'b0;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic        ex_valid;
    alu_op_t     ex_alu_op;
    logic [31:0] ex_imm;
    logic        ex_use_imm;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_illegal;
    branch_t     ex_branch;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc;

    int n_cmp = 0;
    int n_fail = 0;

    id_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_ready     (if_ready),
        .flush        (flush),
        .ex_hold      (ex_hold),
        .Rs1          (Rs1),
        .Rs2          (Rs2),
        .ex_valid     (ex_valid),
        .ex_alu_op    (ex_alu_op),
        .ex_imm       (ex_imm),
        .ex_use_imm   (ex_use_imm),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_illegal   (ex_illegal),
        .ex_branch    (ex_branch),
        .ex_rd        (ex_rd),
        .ex_pc        (ex_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        if_valid = v;
        if_instr = instr;
        if_pc    = pc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 32'h00221820, 32'h0000_0040);
        step();
        step();
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", ex_valid); end
        n_cmp++; if (ex_rd !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_rd: got %0d expected 0", ex_rd); end
        n_cmp++; if (ex_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected 0", ex_pc); end
        n_cmp++; if (ex_imm !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_imm: got %h expected 0", ex_imm); end
        n_cmp++; if (ex_alu_op !== ALU_ADD) begin n_fail++; $display("[TB] FAIL reset_alu: got %0d expected %0d", ex_alu_op, ALU_ADD); end
        n_cmp++; if (ex_branch !== BR_NONE) begin n_fail++; $display("[TB] FAIL reset_branch: got %0d expected %0d", ex_branch, BR_NONE); end
        n_cmp++; if ({ex_use_imm, ex_mem_read, ex_mem_write, ex_illegal} !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 0000", {ex_use_imm, ex_mem_read, ex_mem_write, ex_illegal}); end
        n_cmp++; if (if_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 0", if_ready); end
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_add();
        drive(1'b1, 32'h00221820, 32'h0000_0100);
        #1;
        n_cmp++; if (Rs1 !== 5'd1) begin n_fail++; $display("[TB] FAIL add_rs1: got %0d expected 1", Rs1); end
        n_cmp++; if (Rs2 !== 5'd2) begin n_fail++; $display("[TB] FAIL add_rs2: got %0d expected 2", Rs2); end
        n_cmp++; if (if_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL add_ready: got %b expected 1", if_ready); end
        step();
        n_cmp++; if (ex_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL add_valid: got %b expected 1", ex_valid); end
        n_cmp++; if (ex_alu_op !== ALU_ADD) begin n_fail++; $display("[TB] FAIL add_alu: got %0d expected %0d", ex_alu_op, ALU_ADD); end
        n_cmp++; if (ex_rd !== 5'd3) begin n_fail++; $display("[TB] FAIL add_rd: got %0d expected 3", ex_rd); end
        n_cmp++; if (ex_pc !== 32'h100) begin n_fail++; $display("[TB] FAIL add_pc: got %h expected 100", ex_pc); end
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h8C250000, 32'h0000_0104);
        step();
        n_cmp++; if (ex_mem_read !== 1'b1) begin n_fail++; $display("[TB] FAIL lw_memread: got %b expected 1", ex_mem_read); end
        n_cmp++; if (ex_rd !== 5'd5) begin n_fail++; $display("[TB] FAIL lw_rd: got %0d expected 5", ex_rd); end
        drive(1'b1, 32'h20A6FFFF, 32'h0000_0108);
        #1;
        n_cmp++; if (if_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL lu_stall_ready: got %b expected 0", if_ready); end
        n_cmp++; if (Rs1 !== 5'd5) begin n_fail++; $display("[TB] FAIL lu_rs1: got %0d expected 5", Rs1); end
        step();
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL lu_bubble: got %b expected 0", ex_valid); end
        n_cmp++; if (ex_rd !== 5'd0) begin n_fail++; $display("[TB] FAIL lu_bubble_rd: got %0d expected 0", ex_rd); end
        n_cmp++; if (if_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL lu_release_ready: got %b expected 1", if_ready); end
        step();
        n_cmp++; if (ex_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL addi_valid: got %b expected 1", ex_valid); end
        n_cmp++; if (ex_rd !== 5'd6) begin n_fail++; $display("[TB] FAIL addi_rd: got %0d expected 6", ex_rd); end
        n_cmp++; if (ex_imm !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL addi_imm: got %h expected ffffffff", ex_imm); end
        n_cmp++; if (ex_use_imm !== 1'b1) begin n_fail++; $display("[TB] FAIL addi_useimm: got %b expected 1", ex_use_imm); end
        n_cmp++; if (ex_pc !== 32'h108) begin n_fail++; $display("[TB] FAIL addi_pc: got %h expected 108", ex_pc); end
    endtask

    task automatic test_lw_r0();
        drive(1'b1, 32'h8C200000, 32'h0000_0110);
        step();
        drive(1'b1, 32'h00023820, 32'h0000_0114);
        #1;
        n_cmp++; if (if_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL lwr0_ready: got %b expected 1", if_ready); end
        step();
        n_cmp++; if (ex_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL lwr0_valid: got %b expected 1", ex_valid); end
        n_cmp++; if (ex_rd !== 5'd7) begin n_fail++; $display("[TB] FAIL lwr0_rd: got %0d expected 7", ex_rd); end
    endtask

    task automatic test_hold();
        drive(1'b1, 32'h8D250004, 32'h0000_0200);
        step();
        drive(1'b1, 32'h00221820, 32'h0000_0204);
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (if_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_ready[%0d]: got %b expected 0", i, if_ready); end
            n_cmp++; if (Rs1 !== 5'd9) begin n_fail++; $display("[TB] FAIL hold_rs1[%0d]: got %0d expected 9", i, Rs1); end
            n_cmp++; if (Rs2 !== 5'd0) begin n_fail++; $display("[TB] FAIL hold_rs2[%0d]: got %0d expected 0", i, Rs2); end
            step();
            n_cmp++; if ({ex_valid, ex_mem_read, ex_rd} !== {1'b1, 1'b1, 5'd5}) begin n_fail++; $display("[TB] FAIL hold_ctrl[%0d]: got %b/%b/%0d expected 1/1/5", i, ex_valid, ex_mem_read, ex_rd); end
            n_cmp++; if ({ex_imm, ex_pc} !== {32'h4, 32'h200}) begin n_fail++; $display("[TB] FAIL hold_data[%0d]: got %h/%h expected 00000004/00000200", i, ex_imm, ex_pc); end
        end
        ex_hold = 1'b0;
        step();
        n_cmp++; if (ex_rd !== 5'd3) begin n_fail++; $display("[TB] FAIL hold_release_rd: got %0d expected 3", ex_rd); end
        n_cmp++; if (ex_pc !== 32'h204) begin n_fail++; $display("[TB] FAIL hold_release_pc: got %h expected 204", ex_pc); end
    endtask

    task automatic test_flush_hold();
        drive(1'b1, 32'h00221820, 32'h0000_0300);
        flush   = 1'b1;
        ex_hold = 1'b1;
        #1;
        n_cmp++; if (if_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_ready: got %b expected 1", if_ready); end
        step();
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_valid: got %b expected 0", ex_valid); end
        n_cmp++; if (ex_rd !== 5'd0) begin n_fail++; $display("[TB] FAIL flush_rd: got %0d expected 0", ex_rd); end
        flush   = 1'b0;
        ex_hold = 1'b0;
    endtask

    task automatic test_illegal();
        drive(1'b1, 32'hFC000000, 32'h0000_0400);
        step();
        n_cmp++; if (ex_illegal !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_flag: got %b expected 1", ex_illegal); end
        n_cmp++; if (ex_rd !== 5'd0) begin n_fail++; $display("[TB] FAIL ill_rd: got %0d expected 0", ex_rd); end
        n_cmp++; if ({ex_mem_read, ex_mem_write} !== 2'b00) begin n_fail++; $display("[TB] FAIL ill_mem: got %b expected 00", {ex_mem_read, ex_mem_write}); end
        n_cmp++; if (ex_branch !== BR_NONE) begin n_fail++; $display("[TB] FAIL ill_branch: got %0d expected %0d", ex_branch, BR_NONE); end
        drive(1'b1, 32'h34028000, 32'h0000_0404);
        step();
        n_cmp++; if (ex_imm !== 32'h0000_8000) begin n_fail++; $display("[TB] FAIL ori_imm: got %h expected 00008000", ex_imm); end
        n_cmp++; if (ex_rd !== 5'd2) begin n_fail++; $display("[TB] FAIL ori_rd: got %0d expected 2", ex_rd); end
        n_cmp++; if (ex_illegal !== 1'b0) begin n_fail++; $display("[TB] FAIL ori_illegal: got %b expected 0", ex_illegal); end
        n_cmp++; if (ex_alu_op !== ALU_OR) begin n_fail++; $display("[TB] FAIL ori_alu: got %0d expected %0d", ex_alu_op, ALU_OR); end
        drive(1'b1, 32'h00221821, 32'h0000_0408);
        #1;
        n_cmp++; if ({Rs1, Rs2} !== 10'd0) begin n_fail++; $display("[TB] FAIL illfn_rs: got %0d/%0d expected 0/0", Rs1, Rs2); end
        step();
        n_cmp++; if ({ex_illegal, ex_rd} !== {1'b1, 5'd0}) begin n_fail++; $display("[TB] FAIL illfn: got %b/%0d expected 1/0", ex_illegal, ex_rd); end
    endtask

    task automatic test_misc_ops();
        drive(1'b1, 32'h0FFFFFFC, 32'h0000_0500);
        step();
        n_cmp++; if (ex_rd !== 5'd31) begin n_fail++; $display("[TB] FAIL jal_rd: got %0d expected 31", ex_rd); end
        n_cmp++; if (ex_imm !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL jal_imm: got %h expected fffffffc", ex_imm); end
        n_cmp++; if (ex_branch !== BR_JAL) begin n_fail++; $display("[TB] FAIL jal_branch: got %0d expected %0d", ex_branch, BR_JAL); end
        drive(1'b1, 32'h3C041234, 32'h0000_0504);
        step();
        n_cmp++; if ({ex_imm, ex_rd} !== {32'h1234_0000, 5'd4}) begin n_fail++; $display("[TB] FAIL lhi: got %h/%0d expected 12340000/4", ex_imm, ex_rd); end
        drive(1'b1, 32'hAC470008, 32'h0000_0508);
        #1;
        n_cmp++; if ({Rs1, Rs2} !== {5'd2, 5'd7}) begin n_fail++; $display("[TB] FAIL sw_rs: got %0d/%0d expected 2/7", Rs1, Rs2); end
        step();
        n_cmp++; if ({ex_mem_write, ex_mem_read, ex_rd} !== {1'b1, 1'b0, 5'd0}) begin n_fail++; $display("[TB] FAIL sw_ctrl: got %b/%b/%0d expected 1/0/0", ex_mem_write, ex_mem_read, ex_rd); end
        n_cmp++; if (ex_imm !== 32'h8) begin n_fail++; $display("[TB] FAIL sw_imm: got %h expected 00000008", ex_imm); end
        drive(1'b1, 32'h1060FFF8, 32'h0000_050C);
        #1;
        n_cmp++; if ({Rs1, Rs2} !== {5'd3, 5'd0}) begin n_fail++; $display("[TB] FAIL beqz_rs: got %0d/%0d expected 3/0", Rs1, Rs2); end
        step();
        n_cmp++; if (ex_branch !== BR_BEQZ) begin n_fail++; $display("[TB] FAIL beqz_branch: got %0d expected %0d", ex_branch, BR_BEQZ); end
        n_cmp++; if ({ex_imm, ex_rd} !== {32'hFFFF_FFF8, 5'd0}) begin n_fail++; $display("[TB] FAIL beqz_data: got %h/%0d expected fffffff8/0", ex_imm, ex_rd); end
        drive(1'b0, 32'h00221820, 32'h0000_0510);
        step();
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL novalid_bubble: got %b expected 0", ex_valid); end
    endtask

    task automatic test_reset_midstall();
        drive(1'b1, 32'h8C250000, 32'h0000_0600);
        step();
        drive(1'b1, 32'h20A6FFFF, 32'h0000_0604);
        reset = 1'b1;
        #1;
        n_cmp++; if (if_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rststall_ready: got %b expected 0", if_ready); end
        step();
        n_cmp++; if ({ex_valid, ex_mem_read, ex_rd} !== {1'b0, 1'b0, 5'd0}) begin n_fail++; $display("[TB] FAIL rststall_bubble: got %b/%b/%0d expected 0/0/0", ex_valid, ex_mem_read, ex_rd); end
        reset = 1'b0;
        #1;
        n_cmp++; if (if_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rststall_resume: got %b expected 1", if_ready); end
        step();
        n_cmp++; if ({ex_valid, ex_rd} !== {1'b1, 5'd6}) begin n_fail++; $display("[TB] FAIL rststall_addi: got %b/%0d expected 1/6", ex_valid, ex_rd); end
        drive(1'b1, 32'h8C250000, 32'h0000_0608);
        step();
        ex_hold = 1'b1;
        reset   = 1'b1;
        step();
        n_cmp++; if ({ex_valid, ex_rd} !== {1'b0, 5'd0}) begin n_fail++; $display("[TB] FAIL rsthold_bubble: got %b/%0d expected 0/0", ex_valid, ex_rd); end
        reset   = 1'b0;
        ex_hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_lw_r0();
        test_hold();
        test_flush_hold();
        test_illegal();
        test_misc_ops();
        test_reset_midstall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
